// File: rtl/switch_pkg.sv
// Shared types and constants for the switch input path.
package switch_pkg;

  // Board oscillator frequency feeding the input logic.
  localparam int HSOSC_HZ = 48_000_000;

  // 5 ms worth of clocks at HSOSC: long enough to outlast typical contact bounce.
  localparam int DEFAULT_DEBOUNCE_CYCLES = HSOSC_HZ / 200;

  // Per-bit debounce state.
  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

endpackage : switch_pkg

// File: rtl/switch_debouncer_bit.sv
// One switch bit: two-flop synchroniser, persistence counter and edge pulses.
// 'change' and 'level_next' expose, combinationally, the update that the next
// clock edge will commit so the parent can react on that same edge.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change,
  output logic level_next
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1;
  logic          sync2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clk domain; sync1 feeds nothing but sync2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The new level has persisted long enough: commit it on this edge.
  always_comb begin
    change = 1'b0;
    if ((state == COUNTING) && (sync2 != level) && (cnt == CNT_MAX)) begin
      change = 1'b1;
    end
    level_next = change ? sync2 : level;
  end

  // Persistence FSM: any return to the old level before the count completes is a glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        STABLE: begin
          if (sync2 != level) begin
            state <= COUNTING;
            cnt   <= CNT_ONE;
          end
        end
        COUNTING: begin
          if (sync2 == level) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            level <= sync2;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Single-cycle edge pulses for the cycle following a committed change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= change & sync2;
      fall <= change & ~sync2;
    end
  end

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Debounced switch bank with edge pulses and a valid/ready snapshot of the
// debounced levels. Each bit is handled independently; this level only
// merges per-bit changes into snapshot events for a consumer.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             chg_valid,
  output logic [WIDTH-1:0] chg_data,
  input  logic             chg_ready,
  output logic             chg_overrun
);

  logic [WIDTH-1:0] bit_change;
  logic [WIDTH-1:0] db_next;
  logic             event_now;
  logic             accept;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk       (clk),
        .reset     (reset),
        .raw       (sw_raw[gi]),
        .level     (sw_db[gi]),
        .rise      (sw_rise[gi]),
        .fall      (sw_fall[gi]),
        .change    (bit_change[gi]),
        .level_next(db_next[gi])
      );
    end
  endgenerate

  assign event_now = |bit_change;
  assign accept    = chg_valid & chg_ready;

  // Snapshot handshake: changes refresh the pending value; overrun marks a
  // refresh that overwrote data the consumer never took.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chg_valid   <= 1'b0;
      chg_data    <= '0;
      chg_overrun <= 1'b0;
    end else if (event_now) begin
      chg_valid <= 1'b1;
      chg_data  <= db_next;
      if (accept) begin
        chg_overrun <= 1'b0;
      end else if (chg_valid) begin
        chg_overrun <= 1'b1;
      end
    end else if (accept) begin
      chg_valid   <= 1'b0;
      chg_overrun <= 1'b0;
    end
  end

endmodule : switch_debouncer
